// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and constants for the register-file writeback path.
package rf_ctrl_pkg;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int NUM_REGS  = 2 ** RF_ADDR_W;
    localparam int REQ_ALU   = 0;
    localparam int REQ_LSU   = 1;
    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; ties go to the requester that did not win last.
module rr_arbiter2
    import rf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic last_grant;
    always_comb gnt = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'(REQ_LSU);
        else if (accept)
            last_grant <= gnt[REQ_LSU];
    end
endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates ALU/LSU writebacks onto the single RF write port
// and tracks pending writes so decode can stall on RAW hazards.
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  wb_err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [1:0]            gnt;
    logic                  accept;
    logic                  wr_hit;
    logic                  err_hit;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_nxt;
    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({lsu_valid, alu_valid}),
        .accept (accept),
        .gnt    (gnt)
    );
    always_comb begin
        alu_ready = gnt[REQ_ALU];
        lsu_ready = gnt[REQ_LSU];
        accept    = (alu_valid & alu_ready) | (lsu_valid & lsu_ready);
        wb_rd     = lsu_ready ? lsu_rd : alu_rd;
        wb_data   = lsu_ready ? lsu_data : alu_data;
        wr_hit    = accept && (wb_rd != '0);
        err_hit   = wr_hit && !pending[wb_rd] && !(issue_valid && issue_rd == wb_rd);
        rs1_busy  = pending[rs1_addr];
        rs2_busy  = pending[rs2_addr];
    end
    // Clear before set so a new producer issued during the retiring write keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (rf_wr_en)
            pending_nxt[rf_wr_addr] = 1'b0;
        if (issue_valid)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            pending    <= '0;
            wb_err     <= 1'b0;
        end else begin
            rf_wr_en <= wr_hit;
            if (wr_hit) begin
                rf_wr_addr <= wb_rd;
                rf_wr_data <= wb_data;
            end
            pending <= pending_nxt;
            wb_err  <= wb_err | err_hit;
        end
    end
endmodule
